// File: rtl/turbo_clock_sequencer.sv
// Turbo clock sequencer: moves the CPU clock-mux select between the normal
// 7 MHz clock and the turbo synthesizer only while the CPU is stalled on an
// idle bus, and drops back to the normal clock if the synthesizer loses lock.
module turbo_clock_sequencer #(
    parameter int unsigned HOLD_TICKS    = 4,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1023
) (
    input  logic clk28m_i,
    input  logic reset_i,
    input  logic clk7_en_i,
    input  logic turbo_req_i,
    input  logic cpu_as_n_i,
    input  logic turbo_locked_i,
    output logic turbo_sel_o,
    output logic cpu_hold_o,
    output logic busy_o,
    output logic turbo_fault_o
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUS,
        HOLD,
        SWITCH,
        SETTLE
    } state_t;

    localparam logic [7:0]  HOLD_CNT    = 8'(HOLD_TICKS);
    localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_TICKS - 1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        reqMeta_q, reqSync_q;
    logic        lockMeta_q, lockSync_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] lockCnt_q, lockCnt_d;
    logic        turboSel_q, turboSel_d;
    logic        fault_q, fault_d;
    logic        force_q, force_d;

    logic        target;
    logic        waitLock;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A forced fallback always heads for the normal clock; otherwise the switch
    // toggles the current select. Waiting for lock only applies to turbo.
    assign target   = !force_q && !turboSel_q;
    assign waitLock = target && !lockSync_q;

    // State register plus the two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk28m_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            reqMeta_q  <= 1'b0;
            reqSync_q  <= 1'b0;
            lockMeta_q <= 1'b0;
            lockSync_q <= 1'b0;
            cnt_q      <= '0;
            lockCnt_q  <= '0;
            turboSel_q <= 1'b0;
            fault_q    <= 1'b0;
            force_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            reqMeta_q  <= turbo_req_i;
            reqSync_q  <= reqMeta_q;
            lockMeta_q <= turbo_locked_i;
            lockSync_q <= lockMeta_q;
            cnt_q      <= cnt_d;
            lockCnt_q  <= lockCnt_d;
            turboSel_q <= turboSel_d;
            fault_q    <= fault_d;
            force_q    <= force_d;
        end
    end

    // Next-state logic: bus-idle qualification, hold/lock timing, select flip and settle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lockCnt_d  = lockCnt_q;
        turboSel_d = turboSel_q;
        fault_d    = fault_q;
        force_d    = force_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                lockCnt_d = '0;
                if (turboSel_q && !lockSync_q) begin
                    fault_d = 1'b1;
                    force_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    if (!reqSync_q) begin
                        fault_d = 1'b0;
                    end
                    if ((reqSync_q != turboSel_q) && !(reqSync_q && fault_q)) begin
                        state_d = WAIT_BUS;
                    end
                end
            end

            WAIT_BUS: begin
                if (turboSel_q && !lockSync_q) begin
                    fault_d = 1'b1;
                    force_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else if (reqSync_q == turboSel_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (clk7_en_i) begin
                    if (!cpu_as_n_i) begin
                        cnt_d = '0;
                    end else if (cnt_q >= 8'd1) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = satInc8(cnt_q);
                    end
                end
            end

            HOLD: begin
                if (cnt_q < HOLD_CNT) begin
                    if (clk7_en_i) begin
                        cnt_d = satInc8(cnt_q);
                        if ((cnt_q == HOLD_LAST) && !waitLock) begin
                            state_d = SWITCH;
                        end
                    end
                end else if (!waitLock) begin
                    state_d = SWITCH;
                end else if (clk7_en_i) begin
                    if (lockCnt_q >= LOCK_LAST) begin
                        fault_d   = 1'b1;
                        force_d   = 1'b0;
                        cnt_d     = '0;
                        lockCnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        lockCnt_d = satInc16(lockCnt_q);
                    end
                end
            end

            SWITCH: begin
                turboSel_d = target;
                cnt_d      = '0;
                lockCnt_d  = '0;
                state_d    = SETTLE;
            end

            SETTLE: begin
                if (cnt_q >= SETTLE_LAST) begin
                    cnt_d   = '0;
                    force_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = satInc8(cnt_q);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state so they never glitch
    always_comb begin
        busy_o        = (state_q != IDLE);
        cpu_hold_o    = (state_q == HOLD) || (state_q == SWITCH) || (state_q == SETTLE);
        turbo_sel_o   = turboSel_q;
        turbo_fault_o = fault_q;
    end

endmodule

// File: tb/tb_turbo_clock_sequencer.sv
// Scoreboard bench for turbo_clock_sequencer: scenario tasks predict every
// change of {busy, cpu_hold, turbo_sel, turbo_fault} and the clk28m edge it
// lands on; an independent monitor compares each observed change in order.
module tb_turbo_clock_sequencer;

    localparam int HOLD_TICKS    = 4;
    localparam int SETTLE_CYCLES = 16;
    localparam int LOCK_TIMEOUT  = 1023;
    localparam int TICK          = 4;
    localparam int FAR           = 1000000;

    logic clk28m       = 1'b0;
    logic reset        = 1'b0;
    logic clk7_en      = 1'b0;
    logic turbo_req    = 1'b0;
    logic cpu_as_n     = 1'b1;
    logic turbo_locked = 1'b1;
    logic turbo_sel;
    logic cpu_hold;
    logic busy;
    logic turbo_fault;

    int checks  = 0;
    int errors  = 0;
    int edgeCnt = 0;
    int nextId  = 0;

    // Bus activity schedule: idle from asRise on, except inside [asDipLo, asDipHi)
    int asRise  = 0;
    int asDipLo = 0;
    int asDipHi = 0;

    typedef struct {
        logic [3:0] vec;
        int         atEdge;
        int         id;
    } exp_t;

    exp_t expQ[$];

    logic [3:0] prevVec = 4'b0000;

    turbo_clock_sequencer #(
        .HOLD_TICKS   (HOLD_TICKS),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk28m_i      (clk28m),
        .reset_i       (reset),
        .clk7_en_i     (clk7_en),
        .turbo_req_i   (turbo_req),
        .cpu_as_n_i    (cpu_as_n),
        .turbo_locked_i(turbo_locked),
        .turbo_sel_o   (turbo_sel),
        .cpu_hold_o    (cpu_hold),
        .busy_o        (busy),
        .turbo_fault_o (turbo_fault)
    );

    // 28 MHz-ish system clock
    always #5 clk28m = ~clk28m;

    // Count rising edges so every prediction can name the exact edge of an event
    always @(posedge clk28m) edgeCnt++;

    function automatic bit asIdleAt(input int e);
        return (e >= asRise) && !((e >= asDipLo) && (e < asDipHi));
    endfunction

    function automatic int nextTick(input int e);
        int t = e;
        while (t % TICK != 0) t++;
        return t;
    endfunction

    // Edge of the second consecutive clk7_en tick that sees an idle bus
    function automatic int findHoldEdge(input int startEdge);
        int e   = nextTick(startEdge);
        int run = 0;
        for (int n = 0; n < 100000; n++) begin
            if (asIdleAt(e)) run++;
            else run = 0;
            if (run == 2) return e;
            e += TICK;
        end
        return -1;
    endfunction

    // clk7_en is a one-in-four strobe; the bus strobe follows the schedule
    always @(negedge clk28m) begin
        clk7_en  = ((edgeCnt + 1) % TICK == 0);
        cpu_as_n = asIdleAt(edgeCnt + 1);
    end

    // Monitor: every change of the output vector must match the oldest prediction
    always @(negedge clk28m) begin : monitor
        logic [3:0] cur;
        exp_t       e;
        cur = {busy, cpu_hold, turbo_sel, turbo_fault};
        if (cur !== prevVec) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: got {busy,hold,sel,fault}=%b at edge %0d, required no change",
                         cur, edgeCnt);
            end else begin
                e = expQ.pop_front();
                if ((cur !== e.vec) || (edgeCnt != e.atEdge)) begin
                    errors++;
                    $display("[TB] FAIL event%0d: got {busy,hold,sel,fault}=%b at edge %0d, required %b at edge %0d",
                             e.id, cur, edgeCnt, e.vec, e.atEdge);
                end
            end
            prevVec = cur;
        end
    end

    // Hard stop in case something waits forever outside the bounded loops
    initial begin
        #(60000 * 10);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushExp(input logic [3:0] v, input int e);
        exp_t x;
        x.vec    = v;
        x.atEdge = e;
        x.id     = nextId;
        nextId++;
        expQ.push_back(x);
    endtask

    task automatic applyStimulus(input logic req, input logic lock, output int nextEdge);
        @(negedge clk28m);
        turbo_req    = req;
        turbo_locked = lock;
        nextEdge     = edgeCnt + 1;
    endtask

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
        end
    endtask

    task automatic waitDrain(input int budget, input int quietCycles);
        int n = 0;
        while ((expQ.size() != 0) && (n < budget)) begin
            @(negedge clk28m);
            n++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d predicted events still pending after %0d cycles, required 0",
                     expQ.size(), n);
            expQ.delete();
        end
        repeat (quietCycles) @(negedge clk28m);
    endtask

    // Full switch toward t with the lock good; bus goes idle asDelay edges after the request
    task automatic runSwitch(input logic t, input int asDelay, input bit withDip);
        int n, h, s;
        repeat ($urandom_range(1, 7)) @(negedge clk28m);
        applyStimulus(t, 1'b1, n);
        asRise = n + asDelay;
        if (withDip) begin
            asDipLo = asRise + int'($urandom_range(1, 8));
            asDipHi = asDipLo + int'($urandom_range(1, 8));
        end else begin
            asDipLo = 0;
            asDipHi = 0;
        end
        h = findHoldEdge(n + 3);
        s = h + TICK * HOLD_TICKS;
        pushExp({1'b1, 1'b0, ~t, 1'b0}, n + 2);
        pushExp({1'b1, 1'b1, ~t, 1'b0}, h);
        pushExp({1'b1, 1'b1, t, 1'b0}, s + 1);
        pushExp({1'b0, 1'b0, t, 1'b0}, s + 1 + SETTLE_CYCLES);
        if (asDelay > 40 * TICK) begin
            while (edgeCnt < n + 40 * TICK) @(negedge clk28m);
            checkOutput("busbusy_hold", cpu_hold, 1'b0);
            checkOutput("busbusy_sel", turbo_sel, ~t);
        end
        waitDrain(s + SETTLE_CYCLES + 40 - edgeCnt, 20);
        checkOutput("switch_sel", turbo_sel, t);
        checkOutput("switch_fault", turbo_fault, 1'b0);
    endtask

    // Request pulse that is withdrawn while the sequencer still waits for the bus
    task automatic runPulse();
        int n, p;
        asRise = edgeCnt + FAR;
        applyStimulus(1'b1, 1'b1, n);
        pushExp(4'b1000, n + 2);
        repeat ($urandom_range(1, 20)) @(negedge clk28m);
        applyStimulus(1'b0, 1'b1, p);
        pushExp(4'b0000, p + 2);
        waitDrain(60, 20);
        checkOutput("pulse_hold", cpu_hold, 1'b0);
        checkOutput("pulse_sel", turbo_sel, 1'b0);
        asRise = 0;
    endtask

    // Turbo request with the synthesizer never locking: abort after the timeout
    task automatic runLockTimeout();
        int n, h, t, q;
        asRise  = 0;
        asDipLo = 0;
        asDipHi = 0;
        applyStimulus(1'b1, 1'b0, n);
        h = findHoldEdge(n + 3);
        t = h + TICK * HOLD_TICKS + TICK * LOCK_TIMEOUT;
        pushExp(4'b1000, n + 2);
        pushExp(4'b1100, h);
        pushExp(4'b0001, t);
        waitDrain(t + 50 - edgeCnt, 60);
        checkOutput("timeout_fault", turbo_fault, 1'b1);
        checkOutput("timeout_sel", turbo_sel, 1'b0);
        checkOutput("timeout_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b1, q);
        pushExp(4'b0000, q + 2);
        waitDrain(30, 10);
    endtask

    // Lock lost while sitting in turbo: forced fallback even with a busy bus
    task automatic runLockLossTurbo();
        int l, f, sw, q, dummy;
        asRise = edgeCnt + FAR;
        applyStimulus(1'b1, 1'b0, l);
        f  = nextTick(l + 3);
        sw = f + TICK * (HOLD_TICKS - 1);
        pushExp(4'b1111, l + 2);
        pushExp(4'b1101, sw + 1);
        pushExp(4'b0001, sw + 1 + SETTLE_CYCLES);
        waitDrain(sw + SETTLE_CYCLES + 40 - edgeCnt, 20);
        applyStimulus(1'b1, 1'b1, dummy);
        repeat (40) @(negedge clk28m);
        checkOutput("lossturbo_noretry_sel", turbo_sel, 1'b0);
        applyStimulus(1'b0, 1'b1, q);
        pushExp(4'b0000, q + 2);
        waitDrain(30, 10);
        asRise = 0;
    endtask

    // Lock lost while waiting for the bus on the way back to normal
    task automatic runLockLossWait();
        int n, l, f, sw, e, dummy;
        asRise = edgeCnt + FAR;
        applyStimulus(1'b0, 1'b1, n);
        pushExp(4'b1010, n + 2);
        repeat ($urandom_range(1, 30)) @(negedge clk28m);
        applyStimulus(1'b0, 1'b0, l);
        f  = nextTick(l + 3);
        sw = f + TICK * (HOLD_TICKS - 1);
        e  = sw + 1 + SETTLE_CYCLES;
        pushExp(4'b1111, l + 2);
        pushExp(4'b1101, sw + 1);
        pushExp(4'b0001, e);
        pushExp(4'b0000, e + 1);
        waitDrain(e + 40 - edgeCnt, 10);
        applyStimulus(1'b0, 1'b1, dummy);
        repeat (10) @(negedge clk28m);
        asRise = 0;
    endtask

    // Reset during the settle window, then a fresh turbo sequence afterwards
    task automatic runResetInSettle();
        int n, h, s, target, r;
        asRise  = 0;
        asDipLo = 0;
        asDipHi = 0;
        applyStimulus(1'b1, 1'b1, n);
        h = findHoldEdge(n + 3);
        s = h + TICK * HOLD_TICKS;
        pushExp(4'b1000, n + 2);
        pushExp(4'b1100, h);
        pushExp(4'b1110, s + 1);
        target = s + 1 + int'($urandom_range(1, SETTLE_CYCLES - 2));
        while (edgeCnt < target) begin
            @(posedge clk28m);
            #2;
        end
        pushExp(4'b0000, edgeCnt);
        reset = 1'b1;
        #1;
        checkOutput("rst_settle_sel", turbo_sel, 1'b0);
        checkOutput("rst_settle_hold", cpu_hold, 1'b0);
        checkOutput("rst_settle_busy", busy, 1'b0);
        checkOutput("rst_settle_fault", turbo_fault, 1'b0);
        repeat (3) @(negedge clk28m);
        @(negedge clk28m);
        reset = 1'b0;
        r = edgeCnt + 1;
        h = findHoldEdge(r + 3);
        s = h + TICK * HOLD_TICKS;
        pushExp(4'b1000, r + 2);
        pushExp(4'b1100, h);
        pushExp(4'b1110, s + 1);
        pushExp(4'b0010, s + 1 + SETTLE_CYCLES);
        waitDrain(s + SETTLE_CYCLES + 40 - edgeCnt, 20);
    endtask

    // Main stimulus sequence
    initial begin
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clk28m);
        checkOutput("reset_sel", turbo_sel, 1'b0);
        checkOutput("reset_hold", cpu_hold, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_fault", turbo_fault, 1'b0);
        @(negedge clk28m);
        reset = 1'b0;
        repeat (5) @(negedge clk28m);

        $display("[TB] basic switch to turbo and back");
        runSwitch(1'b1, 0, 1'b0);
        runSwitch(1'b0, int'($urandom_range(0, 20)), 1'b0);

        $display("[TB] bus busy for 40 ticks before going idle");
        runSwitch(1'b1, 170 + int'($urandom_range(0, 20)), 1'b0);
        runSwitch(1'b0, int'($urandom_range(0, 20)), 1'b1);

        $display("[TB] randomized bus activity");
        for (int i = 0; i < 4; i++) begin
            runSwitch(1'b1, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
            runSwitch(1'b0, int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] request pulse withdrawn during bus wait");
        runPulse();

        $display("[TB] lock timeout");
        runLockTimeout();

        $display("[TB] lock loss in turbo steady state");
        runSwitch(1'b1, int'($urandom_range(0, 10)), 1'b0);
        runLockLossTurbo();

        $display("[TB] lock loss during bus wait");
        runSwitch(1'b1, int'($urandom_range(0, 10)), 1'b0);
        runLockLossWait();

        $display("[TB] reset during settle");
        runResetInSettle();
        runSwitch(1'b0, int'($urandom_range(0, 10)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/turbo_clock_sequencer.md
Name: turbo_clock_sequencer

Overview:
- Controls CPU clock-mux select (normal 7 MHz vs turbo synthesized clock) so a switch never happens mid-bus-cycle or onto an unlocked synthesizer.
- Lives in the clk28m domain beside the clock generator.
- Takes the OSD turbo request, waits for CPU bus idle, stalls the CPU, flips the select, lets the mux settle, then releases the CPU.
- Falls back to normal clock on synthesizer lock loss.

Parameters:
- HOLD_TICKS, 4: clk7_en ticks of CPU hold before the select changes (range 1..255).
- SETTLE_CYCLES, 16: clk28m cycles after the select change before hold is released (range 1..255).
- LOCK_TIMEOUT, 1023: clk7_en ticks to wait for turbo synthesizer lock before aborting (range 1..65535).

Ports:
- clk28m  in  1  28 MHz system clock; only clock.
- reset  in  1  asynchronous, active-high reset.
- clk7_en  in  1  one-cycle 7 MHz enable, clk28m domain.
- turbo_req  in  1  requested mode, 1 = turbo; asynchronous level, synchronised internally.
- cpu_as_n  in  1  CPU address strobe, low = bus cycle in progress.
- turbo_locked  in  1  turbo synthesizer lock, asynchronous; synchronised internally.
- turbo_sel  out  1  clock-mux select, 1 = turbo.
- cpu_hold  out  1  stalls CPU bus start while high.
- busy  out  1  high in any state other than IDLE.
- turbo_fault  out  1  sticky: a turbo switch was aborted, or lock was lost while in turbo.

Behaviour:
- Reset values: turbo_sel=0, cpu_hold=0, busy=0, turbo_fault=0, state IDLE, all counters 0, synchronisers 0.
- Reset asserted mid-sequence forces these values on the next edge-independent assertion.
- Synchronisers: turbo_req and turbo_locked each pass through 2 flops, giving req_s and lock_s.
  - Latency from input to the synchronised value is 2 clk28m edges.
- Tick counters advance only on cycles where clk7_en=1; SETTLE counts raw clk28m cycles.
- IDLE:
  - If turbo_sel=1 and lock_s=0: set turbo_fault, set force, go to HOLD.
  - Else if req_s != turbo_sel and !(req_s=1 and turbo_fault=1): go to WAIT_BUS.
  - turbo_fault clears in IDLE when req_s=0.
- WAIT_BUS:
  - If req_s == turbo_sel, return to IDLE. No hold is asserted.
  - Otherwise count consecutive clk7_en ticks with cpu_as_n=1. Any clk7_en with cpu_as_n=0 resets the count.
  - At count 2, go to HOLD.
- HOLD:
  - cpu_hold=1 from the entry cycle.
  - Count HOLD_TICKS clk7_en ticks.
  - Target is 1 when the switch is to turbo, unless force is set, in which case target is 0.
  - When the count is reached:
    - If target=1 and lock_s=0, wait in HOLD, counting lock-wait ticks.
    - When lock-wait ticks reach LOCK_TIMEOUT: set turbo_fault, release hold, go to IDLE with turbo_sel unchanged.
    - If target=0, or lock_s=1, go to SWITCH.
- SWITCH: one cycle; turbo_sel <= target on exit; go to SETTLE.
- SETTLE:
  - cpu_hold stays 1 for SETTLE_CYCLES clk28m cycles.
  - Then cpu_hold=0, force=0, go to IDLE.
- Request changes during HOLD, SWITCH and SETTLE are ignored; they are re-evaluated in IDLE.
- Lock loss while the sequence is in HOLD with target=1 (already past the hold count) keeps waiting until LOCK_TIMEOUT.
- Lock loss while turbo_sel=1 and the sequence is in WAIT_BUS: abandon, set force and turbo_fault, go to HOLD.
- Counters saturate, never wrap.
- busy = (state != IDLE).
- Minimum switch latency from a turbo_req edge, with bus idle and locked: 2 sync + 1 + ~2 ticks + HOLD_TICKS ticks + 1 + SETTLE_CYCLES clk28m cycles.

Test Plan:
- Reset, then turbo_req 0->1, cpu_as_n=1, turbo_locked=1, defaults:
  - busy rises 3 cycles after the req edge.
  - cpu_hold rises after 2 clk7_en ticks.
  - turbo_sel=1 after 4 further ticks + 1 cycle.
  - cpu_hold falls 16 cycles later.
  - turbo_fault=0.
- turbo_req=1 with cpu_as_n=0 held for 40 ticks:
  - cpu_hold stays 0 and turbo_sel stays 0.
  - After cpu_as_n rises, the normal sequence completes.
- turbo_req=1 with turbo_locked=0:
  - After 4+1023 ticks, turbo_fault=1, cpu_hold=0, turbo_sel=0.
  - turbo_req stays 1, no retry.
  - turbo_req=0 clears turbo_fault.
- In turbo steady state, drop turbo_locked:
  - HOLD is entered without a bus wait even with cpu_as_n=0.
  - turbo_sel=0 after 4 ticks + 1; turbo_fault=1.
- turbo_req pulses 1 then 0 within WAIT_BUS:
  - Returns to IDLE; cpu_hold never asserts; turbo_sel=0.
- Assert reset during SETTLE with turbo_sel=1:
  - All outputs are 0 immediately.
  - After release with turbo_req=1, a fresh sequence runs.
